// File: rtl/pulse_adder_n.sv
// pulse_adder_n: clocked N-input pulse adder. Counts data pulses between
// strobe events, checks setup/hold/separation/extra-pulse timing per window,
// and emits the count (or a flagged result) DELAY cycles after the strobe.
module pulse_adder_n #(
  parameter int unsigned N_IN    = 2,
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_HOLD  = 1,
  parameter int unsigned T_SEP   = 2,
  parameter int unsigned DELAY   = 8,
  parameter int unsigned WARN_W  = 8,
  localparam int unsigned OUT_W  = $clog2(N_IN + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              strobe,
  input  logic [N_IN-1:0]   din,
  output logic [OUT_W-1:0]  sum_out,
  output logic              out_valid,
  output logic              viol_flag,
  output logic [2:0]        viol_code,
  output logic [WARN_W-1:0] warn_count
);

  localparam int unsigned AGE_MAX = (T_SETUP > T_SEP) ? T_SETUP : T_SEP;
  localparam int unsigned AGE_W   = (AGE_MAX < 1) ? 1 : $clog2(AGE_MAX + 1);
  localparam int unsigned HCNT_W  = (T_HOLD < 2) ? 1 : $clog2(T_HOLD);
  localparam int unsigned HLOAD_I = (T_HOLD > 0) ? T_HOLD - 1 : 0;
  localparam int unsigned ASTRT_I = (AGE_MAX > 0) ? 1 : 0;

  localparam logic [AGE_W-1:0]  MAX_L   = AGE_W'(AGE_MAX);
  localparam logic [AGE_W-1:0]  SETUP_L = AGE_W'(T_SETUP);
  localparam logic [AGE_W-1:0]  SEP_L   = AGE_W'(T_SEP);
  localparam logic [AGE_W-1:0]  START_L = AGE_W'(ASTRT_I);
  localparam logic [HCNT_W-1:0] HLOAD_L = HCNT_W'(HLOAD_I);

  typedef enum logic {OPEN, HOLD} state_t;

  state_t              state, state_nx;
  logic [HCNT_W-1:0]   hcnt, hcnt_nx;

  logic                strobe_q;
  logic [N_IN-1:0]     din_q;
  logic                ev_s;
  logic [N_IN-1:0]     ev_d;

  logic [AGE_W-1:0]    age     [N_IN];
  logic [AGE_W-1:0]    age_eff [N_IN];

  logic [N_IN-1:0]     pending, pend_all;
  logic                extra_r, sep_r, hold_r;
  logic                extra_now, sep_now, hold_now;
  logic                setup_hit, sep_hit, bit0;
  logic [OUT_W-1:0]    count, push_sum;
  logic [2:0]          code;
  logic                flagged, push;

  logic                pipe_v    [DELAY];
  logic [OUT_W-1:0]    pipe_sum  [DELAY];
  logic                pipe_f    [DELAY];
  logic [2:0]          pipe_code [DELAY];

  // Previous-sample registers for rising-edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      strobe_q <= 1'b0;
      din_q    <= '0;
    end else begin
      strobe_q <= strobe;
      din_q    <= din;
    end
  end

  // Edge detect, window bookkeeping and closing-window evaluation.
  // Events coinciding with the strobe are folded into the closing window
  // (age 0), so the new window always starts clean.
  always_comb begin
    ev_s      = strobe & ~strobe_q;
    ev_d      = din & ~din_q;
    pend_all  = pending | ev_d;
    extra_now = extra_r | (|(ev_d & pending));
    hold_now  = hold_r | ((state == HOLD) & (|ev_d));
    setup_hit = 1'b0;
    sep_hit   = 1'b0;
    count     = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      age_eff[i] = ev_d[i] ? '0 : age[i];
    end
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (pend_all[i] && (age_eff[i] < SETUP_L)) setup_hit = 1'b1;
      count = count + OUT_W'(pend_all[i]);
      for (int unsigned j = 0; j < N_IN; j++) begin
        if ((i != j) && ev_d[i] && pend_all[j] && (age_eff[j] < SEP_L)) sep_hit = 1'b1;
      end
    end
    sep_now  = sep_r | sep_hit;
    bit0     = setup_hit | hold_now | ((state == HOLD) & ev_s);
    code     = {extra_now, sep_now, bit0};
    flagged  = |code;
    push     = ev_s & ((count != '0) | flagged);
    push_sum = flagged ? '0 : count;
  end

  // Per-channel age counters, saturating at the longest timing window
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_IN; i++) age[i] <= MAX_L;
    end else begin
      for (int unsigned i = 0; i < N_IN; i++) begin
        if (ev_d[i])             age[i] <= START_L;
        else if (age[i] < MAX_L) age[i] <= age[i] + 1'b1;
      end
    end
  end

  // Window accumulation; everything is cleared when a strobe closes the window
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending <= '0;
      extra_r <= 1'b0;
      sep_r   <= 1'b0;
      hold_r  <= 1'b0;
    end else if (ev_s) begin
      pending <= '0;
      extra_r <= 1'b0;
      sep_r   <= 1'b0;
      hold_r  <= 1'b0;
    end else begin
      pending <= pend_all;
      extra_r <= extra_now;
      sep_r   <= sep_now;
      hold_r  <= hold_now;
    end
  end

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= OPEN;
      hcnt  <= '0;
    end else begin
      state <= state_nx;
      hcnt  <= hcnt_nx;
    end
  end

  // FSM next state: a strobe (re)starts HOLD for T_HOLD cycles
  always_comb begin
    state_nx = state;
    hcnt_nx  = hcnt;
    if (ev_s && (T_HOLD > 0)) begin
      state_nx = HOLD;
      hcnt_nx  = HLOAD_L;
    end else if (state == HOLD) begin
      if (hcnt == '0) state_nx = OPEN;
      else            hcnt_nx  = hcnt - 1'b1;
    end
  end

  // Delay pipeline: one slot per cycle so any strobe spacing is preserved
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned k = 0; k < DELAY; k++) begin
        pipe_v[k]    <= 1'b0;
        pipe_sum[k]  <= '0;
        pipe_f[k]    <= 1'b0;
        pipe_code[k] <= '0;
      end
    end else begin
      pipe_v[0]    <= push;
      pipe_sum[0]  <= push ? push_sum : '0;
      pipe_f[0]    <= push & flagged;
      pipe_code[0] <= push ? code : '0;
      for (int unsigned k = 1; k < DELAY; k++) begin
        pipe_v[k]    <= pipe_v[k-1];
        pipe_sum[k]  <= pipe_sum[k-1];
        pipe_f[k]    <= pipe_f[k-1];
        pipe_code[k] <= pipe_code[k-1];
      end
    end
  end

  assign out_valid = pipe_v[DELAY-1];
  assign sum_out   = pipe_sum[DELAY-1];
  assign viol_flag = pipe_f[DELAY-1];
  assign viol_code = pipe_code[DELAY-1];

  // Saturating count of flagged results
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      warn_count <= '0;
    end else if (out_valid && viol_flag && (warn_count != '1)) begin
      warn_count <= warn_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_pulse_adder_n.sv
// Directed testbench for pulse_adder_n (N_IN=3, T_SETUP=4, T_HOLD=1,
// T_SEP=2, DELAY=8, WARN_W=8). Result word = {out_valid, sum_out, viol_flag, viol_code}.
module tb_pulse_adder_n;

  logic       clock = 1'b0;
  logic       reset;
  logic       strobe;
  logic [2:0] din;
  logic [1:0] sum_out;
  logic       out_valid;
  logic       viol_flag;
  logic [2:0] viol_code;
  logic [7:0] warn_count;

  int checks = 0;
  int errors = 0;

  pulse_adder_n #(
    .N_IN(3), .T_SETUP(4), .T_HOLD(1), .T_SEP(2), .DELAY(8), .WARN_W(8)
  ) dut (
    .clock(clock), .reset(reset), .strobe(strobe), .din(din),
    .sum_out(sum_out), .out_valid(out_valid), .viol_flag(viol_flag),
    .viol_code(viol_code), .warn_count(warn_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  function automatic logic [6:0] obs();
    return {out_valid, sum_out, viol_flag, viol_code};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drives one cycle; on return the state of the following cycle is visible
  task automatic drive_cycle(input logic s, input logic [2:0] d);
    strobe = s;
    din    = d;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; strobe = 1'b0; din = '0;
    repeat (3) step();
    checks++;
    if (obs() !== 7'b0) begin
      errors++; $display("FAIL reset_outputs: got %b required %b", obs(), 7'b0);
    end
    checks++;
    if (warn_count !== 8'd0) begin
      errors++; $display("FAIL reset_warn: got %0d required 0", warn_count);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    for (int c = 0; c < 40; c++) begin
      drive_cycle(c == 30, (c == 10) ? 3'b001 : (c == 13) ? 3'b100 : 3'b000);
      if (c == 36) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL basic_early: out_valid got %b required 0", out_valid);
        end
      end
      if (c == 37) begin
        checks++;
        if (obs() !== 7'b1_10_0_000) begin
          errors++; $display("FAIL basic_result: got %b required %b", obs(), 7'b1_10_0_000);
        end
      end
      if (c == 38) begin
        checks++;
        if (obs() !== 7'b0) begin
          errors++; $display("FAIL basic_clear: got %b required %b", obs(), 7'b0);
        end
      end
    end
  endtask

  task automatic test_setup();
    for (int c = 0; c < 40; c++) begin
      drive_cycle(c == 30, (c == 28) ? 3'b010 : 3'b000);
      if (c == 37) begin
        checks++;
        if (obs() !== 7'b1_00_1_001) begin
          errors++; $display("FAIL setup_result: got %b required %b", obs(), 7'b1_00_1_001);
        end
      end
      if (c == 38) begin
        checks++;
        if (warn_count !== 8'd1) begin
          errors++; $display("FAIL setup_warn: got %0d required 1", warn_count);
        end
      end
    end
  endtask

  task automatic test_separation();
    for (int c = 0; c < 40; c++) begin
      drive_cycle(c == 30, (c == 12) ? 3'b011 : 3'b000);
      if (c == 37) begin
        checks++;
        if (obs() !== 7'b1_00_1_010) begin
          errors++; $display("FAIL sep_simultaneous: got %b required %b", obs(), 7'b1_00_1_010);
        end
      end
    end
    for (int c = 0; c < 40; c++) begin
      drive_cycle(c == 30, (c == 12) ? 3'b001 : (c == 14) ? 3'b010 : 3'b000);
      if (c == 37) begin
        checks++;
        if (obs() !== 7'b1_10_0_000) begin
          errors++; $display("FAIL sep_boundary_ok: got %b required %b", obs(), 7'b1_10_0_000);
        end
      end
    end
  endtask

  task automatic test_extra_hold();
    for (int c = 0; c < 80; c++) begin
      drive_cycle((c == 30) || (c == 40) || (c == 60),
                  ((c == 5) || (c == 9)) ? 3'b100 : (c == 41) ? 3'b001 : 3'b000);
      if (c == 37) begin
        checks++;
        if (obs() !== 7'b1_00_1_100) begin
          errors++; $display("FAIL extra_result: got %b required %b", obs(), 7'b1_00_1_100);
        end
      end
      if (c == 47) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++; $display("FAIL empty_window: out_valid got %b required 0", out_valid);
        end
      end
      if (c == 67) begin
        checks++;
        if (obs() !== 7'b1_00_1_001) begin
          errors++; $display("FAIL hold_result: got %b required %b", obs(), 7'b1_00_1_001);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int n_valid = 0;
    for (int c = 0; c < 41; c++) begin
      drive_cycle((c == 20) || (c == 23) || (c == 26), (c == 10) ? 3'b001 : 3'b000);
      if (out_valid === 1'b1) n_valid++;
      if (c == 27) begin
        checks++;
        if (obs() !== 7'b1_01_0_000) begin
          errors++; $display("FAIL b2b_result: got %b required %b", obs(), 7'b1_01_0_000);
        end
      end
    end
    checks++;
    if (n_valid != 1) begin
      errors++; $display("FAIL b2b_count: got %0d results required 1", n_valid);
    end
  endtask

  task automatic test_reset_inflight();
    int n_valid = 0;
    for (int c = 0; c < 32; c++) begin
      reset = (c >= 15) && (c < 17);
      drive_cycle(c == 12, (c == 11) ? 3'b010 : 3'b000);
      if (out_valid === 1'b1) n_valid++;
    end
    reset = 1'b0;
    checks++;
    if (n_valid != 0) begin
      errors++; $display("FAIL inflight_discard: got %0d results required 0", n_valid);
    end
    checks++;
    if (warn_count !== 8'd0) begin
      errors++; $display("FAIL inflight_warn: got %0d required 0", warn_count);
    end
  endtask

  task automatic test_warn_saturation();
    for (int w = 0; w < 100; w++) begin
      drive_cycle(1'b1, 3'b001);
      drive_cycle(1'b0, 3'b000);
      if (w == 3) begin
        checks++;
        if (obs() !== 7'b1_00_1_001) begin
          errors++; $display("FAIL same_cycle_setup: got %b required %b", obs(), 7'b1_00_1_001);
        end
      end
    end
    repeat (10) drive_cycle(1'b0, 3'b000);
    checks++;
    if (warn_count !== 8'd100) begin
      errors++; $display("FAIL warn_100: got %0d required 100", warn_count);
    end
    for (int w = 0; w < 200; w++) begin
      drive_cycle(1'b1, 3'b001);
      drive_cycle(1'b0, 3'b000);
    end
    repeat (10) drive_cycle(1'b0, 3'b000);
    checks++;
    if (warn_count !== 8'd255) begin
      errors++; $display("FAIL warn_saturate: got %0d required 255", warn_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_setup();
    test_separation();
    test_extra_hold();
    test_back_to_back();
    test_reset_inflight();
    test_warn_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
